// File: rtl/oklab_conv_arb.sv
// oklab_conv_arb: line-granular round-robin arbiter that time-shares one
// ycbcr2oklab converter between two YCbCr line sources. A whole line
// (hstr..hend) is granted to one source, its pixels and syncs are registered
// into the converter, and a source tag follows the converter latency so the
// converter output can be attributed back to the right source.
//
// Optional feature: define OKLAB_ARB_LINECNT_EN to add per-source completed
// line counters (o_lcnt0/1) with a synchronous clear input (i_lcnt_clr).

module oklab_conv_arb #(
    parameter int CIW      = 12,
    parameter int PIPE_LAT = 8
`ifdef OKLAB_ARB_LINECNT_EN
    ,
    parameter int CNT_W    = 12
`endif
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           i_req0,
    input  logic           i_req1,
    output logic           o_gnt0,
    output logic           o_gnt1,

    input  logic [CIW-1:0] i_y0,
    input  logic [CIW:0]   i_cb0_sgn,
    input  logic [CIW:0]   i_cr0_sgn,
    input  logic           i_hstr0,
    input  logic           i_hend0,
    input  logic           i_href0,

    input  logic [CIW-1:0] i_y1,
    input  logic [CIW:0]   i_cb1_sgn,
    input  logic [CIW:0]   i_cr1_sgn,
    input  logic           i_hstr1,
    input  logic           i_hend1,
    input  logic           i_href1,

    output logic [CIW-1:0] o_conv_y,
    output logic [CIW:0]   o_conv_cb_sgn,
    output logic [CIW:0]   o_conv_cr_sgn,
    output logic           o_conv_hstr,
    output logic           o_conv_hend,
    output logic           o_conv_href,

    input  logic           i_conv_hend,
    output logic           o_tag,
    output logic           o_line_done0,
    output logic           o_line_done1,
    output logic           o_err
`ifdef OKLAB_ARB_LINECNT_EN
    ,
    input  logic             i_lcnt_clr,
    output logic [CNT_W-1:0] o_lcnt0,
    output logic [CNT_W-1:0] o_lcnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   last_nxt;
    logic   tag_r;
    logic [PIPE_LAT-1:0] tag_pipe;

    // Next-state logic: grant a whole line, alternate on ties, release on the owner's hend.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (i_req0 && i_req1) begin
                    if (last) begin
                        state_nxt = BUSY0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = BUSY1;
                        last_nxt  = 1'b1;
                    end
                end else if (i_req0) begin
                    state_nxt = BUSY0;
                    last_nxt  = 1'b0;
                end else if (i_req1) begin
                    state_nxt = BUSY1;
                    last_nxt  = 1'b1;
                end
            end
            BUSY0: begin
                if (i_hend0) begin
                    state_nxt = IDLE;
                end
            end
            BUSY1: begin
                if (i_hend1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; last starts at 1 so source 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    assign o_gnt0 = (state == BUSY0);
    assign o_gnt1 = (state == BUSY1);

    // Registered mux into the converter; syncs drop and data holds while nobody owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_conv_y      <= '0;
            o_conv_cb_sgn <= '0;
            o_conv_cr_sgn <= '0;
            o_conv_hstr   <= 1'b0;
            o_conv_hend   <= 1'b0;
            o_conv_href   <= 1'b0;
            tag_r         <= 1'b0;
        end else begin
            tag_r <= (state == BUSY1);
            case (state)
                BUSY0: begin
                    o_conv_y      <= i_y0;
                    o_conv_cb_sgn <= i_cb0_sgn;
                    o_conv_cr_sgn <= i_cr0_sgn;
                    o_conv_hstr   <= i_hstr0;
                    o_conv_hend   <= i_hend0;
                    o_conv_href   <= i_href0;
                end
                BUSY1: begin
                    o_conv_y      <= i_y1;
                    o_conv_cb_sgn <= i_cb1_sgn;
                    o_conv_cr_sgn <= i_cr1_sgn;
                    o_conv_hstr   <= i_hstr1;
                    o_conv_hend   <= i_hend1;
                    o_conv_href   <= i_href1;
                end
                default: begin
                    o_conv_hstr   <= 1'b0;
                    o_conv_hend   <= 1'b0;
                    o_conv_href   <= 1'b0;
                end
            endcase
        end
    end

    // Tag delay line matched to converter latency; shifts every cycle so adjacent lines never alias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= tag_r;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign o_tag = tag_pipe[PIPE_LAT-1];

    // Line-done pulses: converter hend attributed by the aligned tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_line_done0 <= 1'b0;
            o_line_done1 <= 1'b0;
        end else begin
            o_line_done0 <= i_conv_hend & ~o_tag;
            o_line_done1 <= i_conv_hend & o_tag;
        end
    end

    // Sticky error: an ungranted source asserted href.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err <= 1'b0;
        end else if ((i_href0 && (state != BUSY0)) || (i_href1 && (state != BUSY1))) begin
            o_err <= 1'b1;
        end
    end

`ifdef OKLAB_ARB_LINECNT_EN
    // Completed-line counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_lcnt0 <= '0;
            o_lcnt1 <= '0;
        end else if (i_lcnt_clr) begin
            o_lcnt0 <= '0;
            o_lcnt1 <= '0;
        end else begin
            if (o_line_done0) begin
                o_lcnt0 <= o_lcnt0 + CNT_W'(1);
            end
            if (o_line_done1) begin
                o_lcnt1 <= o_lcnt1 + CNT_W'(1);
            end
        end
    end
`else
    // No line counters in this build.
`endif

endmodule

// File: tb/tb_oklab_conv_arb.sv
// Testbench for oklab_conv_arb: directed scenarios with hand-computed
// expectations. A small shift register stands in for the converter, returning
// o_conv_hend as i_conv_hend PIPE_LAT cycles later. Counter scenario is only
// built when OKLAB_ARB_LINECNT_EN is defined.

module tb_oklab_conv_arb;

    localparam int CIW      = 12;
    localparam int PIPE_LAT = 8;

    logic           clk;
    logic           rst_n;
    logic           i_req0, i_req1;
    logic           o_gnt0, o_gnt1;
    logic [CIW-1:0] i_y0, i_y1;
    logic [CIW:0]   i_cb0_sgn, i_cr0_sgn, i_cb1_sgn, i_cr1_sgn;
    logic           i_hstr0, i_hend0, i_href0;
    logic           i_hstr1, i_hend1, i_href1;
    logic [CIW-1:0] o_conv_y;
    logic [CIW:0]   o_conv_cb_sgn, o_conv_cr_sgn;
    logic           o_conv_hstr, o_conv_hend, o_conv_href;
    logic           i_conv_hend;
    logic           o_tag;
    logic           o_line_done0, o_line_done1;
    logic           o_err;
`ifdef OKLAB_ARB_LINECNT_EN
    logic           i_lcnt_clr;
    logic [11:0]    o_lcnt0, o_lcnt1;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mon_n, mon_d0, mon_d1;

    logic [PIPE_LAT-1:0] conv_sr;

    oklab_conv_arb #(
        .CIW(CIW),
        .PIPE_LAT(PIPE_LAT)
`ifdef OKLAB_ARB_LINECNT_EN
        ,
        .CNT_W(12)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0(i_req0), .i_req1(i_req1), .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .i_y0(i_y0), .i_cb0_sgn(i_cb0_sgn), .i_cr0_sgn(i_cr0_sgn),
        .i_hstr0(i_hstr0), .i_hend0(i_hend0), .i_href0(i_href0),
        .i_y1(i_y1), .i_cb1_sgn(i_cb1_sgn), .i_cr1_sgn(i_cr1_sgn),
        .i_hstr1(i_hstr1), .i_hend1(i_hend1), .i_href1(i_href1),
        .o_conv_y(o_conv_y), .o_conv_cb_sgn(o_conv_cb_sgn), .o_conv_cr_sgn(o_conv_cr_sgn),
        .o_conv_hstr(o_conv_hstr), .o_conv_hend(o_conv_hend), .o_conv_href(o_conv_href),
        .i_conv_hend(i_conv_hend), .o_tag(o_tag),
        .o_line_done0(o_line_done0), .o_line_done1(o_line_done1), .o_err(o_err)
`ifdef OKLAB_ARB_LINECNT_EN
        ,
        .i_lcnt_clr(i_lcnt_clr), .o_lcnt0(o_lcnt0), .o_lcnt1(o_lcnt1)
`endif
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in converter: returns o_conv_hend after PIPE_LAT cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) conv_sr <= '0;
        else        conv_sr <= {conv_sr[PIPE_LAT-2:0], o_conv_hend};
    end
    assign i_conv_hend = conv_sr[PIPE_LAT-1];

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_src;
        i_hstr0 = 0; i_hend0 = 0; i_href0 = 0;
        i_hstr1 = 0; i_hend1 = 0; i_href1 = 0;
    endtask

    task automatic set_px(input int src, input logic hs, input logic he, input logic hr,
                          input logic [CIW-1:0] y, input logic [CIW:0] cb, input logic [CIW:0] cr);
        if (src == 0) begin
            i_hstr0 = hs; i_hend0 = he; i_href0 = hr; i_y0 = y; i_cb0_sgn = cb; i_cr0_sgn = cr;
        end else begin
            i_hstr1 = hs; i_hend1 = he; i_href1 = hr; i_y1 = y; i_cb1_sgn = cb; i_cr1_sgn = cr;
        end
    endtask

    task automatic send_line(input int src, input int npx, input logic [CIW-1:0] y,
                             input logic [CIW:0] cb, input logic [CIW:0] cr);
        for (int p = 0; p < npx; p++) begin
            set_px(src, p == 0, p == npx - 1, 1'b1, y, cb, cr);
            step;
        end
        clear_src;
    endtask

    task automatic do_reset;
        rst_n = 0;
        i_req0 = 0; i_req1 = 0;
        clear_src;
        i_y0 = '0; i_y1 = '0;
        i_cb0_sgn = '0; i_cr0_sgn = '0; i_cb1_sgn = '0; i_cr1_sgn = '0;
`ifdef OKLAB_ARB_LINECNT_EN
        i_lcnt_clr = 0;
`endif
        repeat (2) step;
        rst_n = 1;
        step;
    endtask

    task automatic test_reset;
        rst_n = 0;
        i_req0 = 0; i_req1 = 0;
        clear_src;
        i_y0 = '0; i_y1 = '0;
        i_cb0_sgn = '0; i_cr0_sgn = '0; i_cb1_sgn = '0; i_cr1_sgn = '0;
`ifdef OKLAB_ARB_LINECNT_EN
        i_lcnt_clr = 0;
`endif
        #3;
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", {o_gnt0, o_gnt1});
        end
        checks++;
        if ({o_conv_hstr, o_conv_hend, o_conv_href} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_syncs: got %b expected 000", {o_conv_hstr, o_conv_hend, o_conv_href});
        end
        checks++;
        if ({o_tag, o_line_done0, o_line_done1, o_err} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {o_tag, o_line_done0, o_line_done1, o_err});
        end
        checks++;
        if (o_conv_y !== 12'h000) begin
            errors++; $display("[TB] FAIL reset_y: got %0h expected 0", o_conv_y);
        end
        do_reset;
    endtask

    task automatic test_single_line;
        int  t_hend;
        bit  seen_done, seen_conv;
        do_reset;
        i_req0 = 1;
        step;
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b10) begin
            errors++; $display("[TB] FAIL t1_gnt: got %b expected 10", {o_gnt0, o_gnt1});
        end
        i_req0 = 0;
        t_hend = 0;
        for (int p = 0; p < 16; p++) begin
            set_px(0, p == 0, p == 15, 1'b1, 12'h100, '0, '0);
            step;
            checks++;
            if (o_conv_href !== 1'b1 || o_conv_y !== 12'h100) begin
                errors++; $display("[TB] FAIL t1_px%0d: got href=%b y=%0h expected href=1 y=100", p, o_conv_href, o_conv_y);
            end
            if (p == 0) begin
                checks++;
                if (o_conv_hstr !== 1'b1) begin
                    errors++; $display("[TB] FAIL t1_hstr: got %b expected 1", o_conv_hstr);
                end
            end
            if (p == 15) begin
                t_hend = cyc;
                checks++;
                if ({o_conv_hend, o_gnt0} !== 2'b10) begin
                    errors++; $display("[TB] FAIL t1_hend_gnt: got %b expected 10", {o_conv_hend, o_gnt0});
                end
            end
        end
        clear_src;
        step;
        checks++;
        if ({o_conv_href, o_conv_hend} !== 2'b00) begin
            errors++; $display("[TB] FAIL t1_after_line: got %b expected 00", {o_conv_href, o_conv_hend});
        end
        seen_done = 0;
        seen_conv = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_line_done0) begin
                seen_done = 1;
                break;
            end
            if (i_conv_hend) begin
                seen_conv = 1;
                checks++;
                if (o_tag !== 1'b0) begin
                    errors++; $display("[TB] FAIL t1_tag: got %b expected 0", o_tag);
                end
            end
            step;
        end
        checks++;
        if (!seen_done || !seen_conv) begin
            errors++; $display("[TB] FAIL t1_done_seen: got done=%b conv=%b expected 1 1", seen_done, seen_conv);
        end
        checks++;
        if (cyc - t_hend != PIPE_LAT + 1) begin
            errors++; $display("[TB] FAIL t1_done_lat: got %0d expected %0d", cyc - t_hend, PIPE_LAT + 1);
        end
        checks++;
        if (o_line_done1 !== 1'b0) begin
            errors++; $display("[TB] FAIL t1_done1: got %b expected 0", o_line_done1);
        end
        step;
        checks++;
        if (o_line_done0 !== 1'b0) begin
            errors++; $display("[TB] FAIL t1_pulse_width: got %b expected 0", o_line_done0);
        end
    endtask

    task automatic test_round_robin;
        do_reset;
        i_req0 = 1; i_req1 = 1;
        step;
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b10) begin
            errors++; $display("[TB] FAIL t2_line1_gnt: got %b expected 10", {o_gnt0, o_gnt1});
        end
        i_req0 = 0;
        send_line(0, 4, 12'h010, 13'h0003, 13'h1FFD);
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b00) begin
            errors++; $display("[TB] FAIL t2_idle_gap: got %b expected 00", {o_gnt0, o_gnt1});
        end
        step;
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b01) begin
            errors++; $display("[TB] FAIL t2_line2_gnt: got %b expected 01", {o_gnt0, o_gnt1});
        end
        i_req1 = 0;
        send_line(1, 4, 12'h020, 13'h1F00, 13'h0055);
        checks++;
        if (o_conv_y !== 12'h020 || o_conv_cb_sgn !== 13'h1F00 || o_conv_cr_sgn !== 13'h0055) begin
            errors++; $display("[TB] FAIL t2_src1_data: got y=%0h cb=%0h cr=%0h expected 20 1f00 55", o_conv_y, o_conv_cb_sgn, o_conv_cr_sgn);
        end
        i_req0 = 1; i_req1 = 1;
        step;
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b10) begin
            errors++; $display("[TB] FAIL t2_line3_gnt: got %b expected 10", {o_gnt0, o_gnt1});
        end
        i_req0 = 0;
        send_line(0, 4, 12'h030, '0, '0);
        step;
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b01) begin
            errors++; $display("[TB] FAIL t2_line4_gnt: got %b expected 01", {o_gnt0, o_gnt1});
        end
        i_req1 = 0;
        send_line(1, 4, 12'h040, '0, '0);
        step;
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b00) begin
            errors++; $display("[TB] FAIL t2_final_idle: got %b expected 00", {o_gnt0, o_gnt1});
        end
        repeat (12) step;
    endtask

    task automatic test_back_to_back;
        do_reset;
        mon_n = 0; mon_d0 = 0; mon_d1 = 0;
        fork
            begin
                i_req0 = 1;
                step;
                for (int k = 0; k < 4; k++) begin
                    if (k % 2 == 0) begin
                        i_req0 = 0;
                        if (k < 3) i_req1 = 1;
                    end else begin
                        i_req1 = 0;
                        if (k < 3) i_req0 = 1;
                    end
                    set_px(k % 2, 1'b1, 1'b1, 1'b1, 12'h050 + 12'(k), '0, '0);
                    step;
                    if (k == 0) begin
                        checks++;
                        if ({o_conv_hstr, o_conv_hend, o_gnt0} !== 3'b110) begin
                            errors++; $display("[TB] FAIL t3_one_px: got %b expected 110", {o_conv_hstr, o_conv_hend, o_gnt0});
                        end
                    end
                    clear_src;
                    step;
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk);
                    #1;
                    if (i_conv_hend) begin
                        checks++;
                        if (mon_n >= 4 || o_tag !== logic'(mon_n % 2)) begin
                            errors++; $display("[TB] FAIL t3_tag%0d: got %b expected %0d", mon_n, o_tag, mon_n % 2);
                        end
                        mon_n++;
                    end
                    if (o_line_done0) mon_d0++;
                    if (o_line_done1) mon_d1++;
                end
            end
        join
        checks++;
        if (mon_n != 4 || mon_d0 != 2 || mon_d1 != 2) begin
            errors++; $display("[TB] FAIL t3_counts: got hend=%0d d0=%0d d1=%0d expected 4 2 2", mon_n, mon_d0, mon_d1);
        end
    endtask

    task automatic test_err;
        do_reset;
        i_req0 = 1;
        step;
        i_req0 = 0;
        checks++;
        if (o_err !== 1'b0) begin
            errors++; $display("[TB] FAIL t4_err_before: got %b expected 0", o_err);
        end
        set_px(0, 1'b1, 1'b0, 1'b1, 12'h0AA, 13'h0011, 13'h0022);
        set_px(1, 1'b0, 1'b0, 1'b1, 12'hFFF, 13'h1FFF, 13'h1FFF);
        step;
        checks++;
        if (o_err !== 1'b1 || o_conv_y !== 12'h0AA || o_conv_cb_sgn !== 13'h0011) begin
            errors++; $display("[TB] FAIL t4_err_set: got err=%b y=%0h cb=%0h expected 1 aa 11", o_err, o_conv_y, o_conv_cb_sgn);
        end
        i_href1 = 0;
        set_px(0, 1'b0, 1'b1, 1'b1, 12'h0AB, 13'h0011, 13'h0022);
        step;
        clear_src;
        repeat (3) step;
        checks++;
        if (o_err !== 1'b1) begin
            errors++; $display("[TB] FAIL t4_err_sticky: got %b expected 1", o_err);
        end
        checks++;
        if (o_conv_y !== 12'h0AB || o_conv_href !== 1'b0) begin
            errors++; $display("[TB] FAIL t4_hold: got y=%0h href=%b expected ab 0", o_conv_y, o_conv_href);
        end
    endtask

    task automatic test_reset_mid_line;
        i_req0 = 1;
        step;
        i_req0 = 0;
        for (int p = 0; p < 5; p++) begin
            set_px(0, p == 0, 1'b0, 1'b1, 12'h123, '0, '0);
            step;
        end
        checks++;
        if ({o_gnt0, o_conv_href, o_err} !== 3'b111) begin
            errors++; $display("[TB] FAIL t5_mid_line: got %b expected 111", {o_gnt0, o_conv_href, o_err});
        end
        set_px(0, 1'b0, 1'b0, 1'b1, 12'h123, '0, '0);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({o_gnt0, o_gnt1, o_conv_hstr, o_conv_hend, o_conv_href} !== 5'b00000) begin
            errors++; $display("[TB] FAIL t5_async_syncs: got %b expected 00000", {o_gnt0, o_gnt1, o_conv_hstr, o_conv_hend, o_conv_href});
        end
        checks++;
        if ({o_tag, o_err, o_line_done0, o_line_done1} !== 4'b0000 || o_conv_y !== 12'h000) begin
            errors++; $display("[TB] FAIL t5_async_flags: got %b y=%0h expected 0000 y=0", {o_tag, o_err, o_line_done0, o_line_done1}, o_conv_y);
        end
        clear_src;
        step;
        rst_n = 1;
        i_req1 = 1;
        step;
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b01) begin
            errors++; $display("[TB] FAIL t5_post_reset_gnt: got %b expected 01", {o_gnt0, o_gnt1});
        end
        i_req1 = 0;
        send_line(1, 1, 12'h0FF, '0, '0);
        repeat (12) step;
    endtask

`ifdef OKLAB_ARB_LINECNT_EN
    task automatic test_line_counter;
        bit seen;
        do_reset;
        for (int n = 0; n < 4097; n++) begin
            i_req0 = 1;
            step;
            i_req0 = 0;
            set_px(0, 1'b1, 1'b1, 1'b1, 12'h001, '0, '0);
            step;
            clear_src;
        end
        repeat (12) step;
        checks++;
        if (o_lcnt0 !== 12'd1 || o_lcnt1 !== 12'd0) begin
            errors++; $display("[TB] FAIL t6_wrap: got lcnt0=%0d lcnt1=%0d expected 1 0", o_lcnt0, o_lcnt1);
        end
        i_req0 = 1;
        step;
        i_req0 = 0;
        set_px(0, 1'b1, 1'b1, 1'b1, 12'h001, '0, '0);
        step;
        clear_src;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (o_line_done0) begin
                seen = 1;
                break;
            end
            step;
        end
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL t6_done_seen: got 0 expected 1");
        end
        i_lcnt_clr = 1;
        step;
        i_lcnt_clr = 0;
        checks++;
        if (o_lcnt0 !== 12'd0) begin
            errors++; $display("[TB] FAIL t6_clr_priority: got %0d expected 0", o_lcnt0);
        end
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        test_reset;
        test_single_line;
        test_round_robin;
        test_back_to_back;
        test_err;
        test_reset_mid_line;
`ifdef OKLAB_ARB_LINECNT_EN
        test_line_counter;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
